// File: rtl/spi_pkg.sv
// Shared register offsets, FSM state type and reset constants for the SPI master slot.
package spi_pkg;

    localparam logic [4:0] SPI_REG_STATUS = 5'd0;
    localparam logic [4:0] SPI_REG_SS     = 5'd1;
    localparam logic [4:0] SPI_REG_CTRL   = 5'd2;
    localparam logic [4:0] SPI_REG_TXDATA = 5'd3;

    localparam logic [15:0] SPI_DVSR_RST = 16'd49;

    typedef enum logic [1:0] {
        IDLE,
        CPHA_DLY,
        P0,
        P1
    } spi_state_t;

endpackage

// File: rtl/spi_master.sv
// Single-byte, full-duplex, MSB-first SPI engine with programmable half-period,
// CPOL and CPHA. Mode settings are latched at start and held for the whole byte.
module spi_master
    import spi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  din,
    input  logic [15:0] dvsr,
    input  logic        cpol,
    input  logic        cpha,
    input  logic        miso,
    output logic [7:0]  dout,
    output logic        ready,
    output logic        sclk,
    output logic        mosi
);

    spi_state_t  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  dout_q, dout_d;
    logic [15:0] dvsr_w_q, dvsr_w_d;
    logic        cpol_w_q, cpol_w_d;
    logic        cpha_w_q, cpha_w_d;
    logic        ready_q, ready_d;
    logic        half_done;

    assign half_done = (cnt_q == dvsr_w_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 16'd1;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        dout_d   = dout_q;
        dvsr_w_d = dvsr_w_q;
        cpol_w_d = cpol_w_q;
        cpha_w_d = cpha_w_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    tx_d     = din;
                    dvsr_w_d = dvsr;
                    cpol_w_d = cpol;
                    cpha_w_d = cpha;
                    bit_d    = '0;
                    state_d  = cpha ? CPHA_DLY : P0;
                end
            end
            CPHA_DLY: begin
                if (half_done) begin
                    cnt_d   = '0;
                    state_d = P0;
                end
            end
            P0: begin
                if (half_done) begin
                    cnt_d   = '0;
                    rx_d    = {rx_q[6:0], miso};
                    state_d = P1;
                end
            end
            P1: begin
                if (half_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        // rx_q already holds all eight samples at this point
                        dout_d  = rx_q;
                        state_d = IDLE;
                    end else begin
                        tx_d    = {tx_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        state_d = P0;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            dout_q   <= '0;
            dvsr_w_q <= SPI_DVSR_RST;
            cpol_w_q <= 1'b0;
            cpha_w_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            dout_q   <= dout_d;
            dvsr_w_q <= dvsr_w_d;
            cpol_w_q <= cpol_w_d;
            cpha_w_q <= cpha_w_d;
            ready_q  <= ready_d;
        end
    end

    // Idle clock follows the live CPOL so a mode change is visible before the next byte.
    always_comb begin
        if (state_q == IDLE)
            sclk = cpol;
        else
            sclk = cpol_w_q ^ (cpha_w_q ? (state_q == P0) : (state_q == P1));
    end

    assign mosi  = (state_q != IDLE) & tx_q[7];
    assign dout  = dout_q;
    assign ready = ready_q;

endmodule

// File: rtl/spi_core.sv
// SPI master I/O slot: register decode plus SS/CTRL registers around spi_master.
// Optional internal loopback of MOSI into the receive path: define SPI_LOOPBACK_EN.
module spi_core
    import spi_pkg::*;
#(
    parameter int SS_WIDTH = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cs,
    input  logic                read,
    input  logic                write,
    input  logic [4:0]          addr,
    input  logic [31:0]         wr_data,
    output logic [31:0]         rd_data,
    output logic                spi_sclk,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic [SS_WIDTH-1:0] spi_ss_n
);

    logic [SS_WIDTH-1:0] ss_q, ss_d;
    logic [15:0]         dvsr_q, dvsr_d;
    logic                cpol_q, cpol_d;
    logic                cpha_q, cpha_d;
    logic                wr_en;
    logic                start;
    logic                ready;
    logic [7:0]          rx_byte;
    logic                miso_int;
    logic                unused_sig;

    assign wr_en = cs & write;
    assign start = wr_en & (addr == SPI_REG_TXDATA) & ready;

    always_comb begin
        ss_d   = ss_q;
        dvsr_d = dvsr_q;
        cpol_d = cpol_q;
        cpha_d = cpha_q;
        if (wr_en) begin
            case (addr)
                SPI_REG_SS:   ss_d = wr_data[SS_WIDTH-1:0];
                SPI_REG_CTRL: begin
                    dvsr_d = wr_data[15:0];
                    cpol_d = wr_data[16];
                    cpha_d = wr_data[17];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_q   <= '1;
            dvsr_q <= SPI_DVSR_RST;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
        end else begin
            ss_q   <= ss_d;
            dvsr_q <= dvsr_d;
            cpol_q <= cpol_d;
            cpha_q <= cpha_d;
        end
    end

`ifdef SPI_LOOPBACK_EN
    logic lpbk_q, lpbk_d;

    always_comb begin
        lpbk_d = lpbk_q;
        if (wr_en && addr == SPI_REG_CTRL)
            lpbk_d = wr_data[18];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lpbk_q <= 1'b0;
        else
            lpbk_q <= lpbk_d;
    end

    assign miso_int = lpbk_q ? spi_mosi : spi_miso;
`else
    assign miso_int = spi_miso;
`endif

    spi_master u_master (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .din   (wr_data[7:0]),
        .dvsr  (dvsr_q),
        .cpol  (cpol_q),
        .cpha  (cpha_q),
        .miso  (miso_int),
        .dout  (rx_byte),
        .ready (ready),
        .sclk  (spi_sclk),
        .mosi  (spi_mosi)
    );

    // Status is the only readable register, so the read strobe is not needed.
    assign rd_data    = {23'b0, ready, rx_byte};
    assign spi_ss_n   = ss_q;
    assign unused_sig = ^{read, wr_data};

endmodule

// File: tb/tb_spi_core.sv
// Directed bench for spi_core with a behavioural SPI slave following CPOL/CPHA.
module tb_spi_core;

    localparam int SS_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            cs;
    logic            read;
    logic            write;
    logic [4:0]      addr;
    logic [31:0]     wr_data;
    logic [31:0]     rd_data;
    logic            spi_sclk;
    logic            spi_mosi;
    logic            spi_miso;
    logic [SS_W-1:0] spi_ss_n;

    int checks   = 0;
    int failures = 0;

    // slave model state
    logic       tb_cpol = 1'b0;
    logic       tb_cpha = 1'b0;
    logic       miso_tie = 1'b0;
    logic [7:0] slv_load = 8'h00;
    logic [7:0] slv_sh = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    int         slv_lead = 0;
    int         slv_samples = 0;
    int         slv_falls = 0;
    logic       arm_tog = 1'b0;
    logic       arm_seen = 1'b0;

    always #5 clk = ~clk;

    spi_core #(.SS_WIDTH(SS_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_ss_n (spi_ss_n)
    );

    assign spi_miso = miso_tie ? 1'b0 : slv_sh[7];

    always @(spi_sclk or arm_tog) begin
        if (arm_tog != arm_seen) begin
            arm_seen    = arm_tog;
            slv_sh      = slv_load;
            slv_rx      = 8'h00;
            slv_lead    = 0;
            slv_samples = 0;
            slv_falls   = 0;
        end else begin
            if (spi_sclk != tb_cpol) begin
                if (tb_cpha) begin
                    if (slv_lead > 0) slv_sh = {slv_sh[6:0], 1'b0};
                    slv_lead++;
                end else begin
                    slv_rx = {slv_rx[6:0], spi_mosi};
                    slv_samples++;
                end
            end else begin
                if (tb_cpha) begin
                    slv_rx = {slv_rx[6:0], spi_mosi};
                    slv_samples++;
                end else begin
                    slv_sh = {slv_sh[6:0], 1'b0};
                end
            end
            if (spi_sclk == 1'b0) slv_falls++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        @(negedge clk);
        cs      = 1'b0;
        write   = 1'b0;
        addr    = 5'd0;
        wr_data = 32'h0;
    endtask

    task automatic arm_slave(input logic [7:0] d);
        slv_load = d;
        arm_tog  = ~arm_tog;
        #1;
    endtask

    task automatic wait_ready(output int low);
        low = 0;
        while (rd_data[8] == 1'b0 && low < 2000) begin
            low++;
            @(negedge clk);
        end
    endtask

    int         low;
    logic [7:0] lb_exp;

    initial begin
        reset   = 1'b1;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = 5'd0;
        wr_data = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ss_n", 32'(spi_ss_n), 32'h3);
        check("rst_sclk", 32'(spi_sclk), 32'h0);
        check("rst_mosi", 32'(spi_mosi), 32'h0);
        check("rst_rd_data", rd_data, 32'h0000_0100);
        $display("reset done rd_data=%h", rd_data);

        // Mode 0, dvsr=1
        write_reg(5'd1, 32'h0);
        write_reg(5'd2, 32'h0000_0001);
        tb_cpol = 1'b0;
        tb_cpha = 1'b0;
        arm_slave(8'h3C);
        write_reg(5'd3, 32'h0000_00A5);
        check("m0_ss_n", 32'(spi_ss_n), 32'h0);
        check("m0_mosi_b7", 32'(spi_mosi), 32'h1);
        wait_ready(low);
        check("m0_ready_low", 32'(low), 32'd32);
        check("m0_rd_data", rd_data, 32'h0000_013C);
        check("m0_slave_rx", 32'(slv_rx), 32'hA5);
        check("m0_samples", 32'(slv_samples), 32'd8);
        $display("xfer mode0 tx=a5 rx=%h slave_rx=%h ready_low=%0d", rd_data[7:0], slv_rx, low);

        // Busy write during a mode 0 transfer is dropped
        arm_slave(8'h66);
        write_reg(5'd3, 32'h0000_003C);
        repeat (4) @(negedge clk);
        write_reg(5'd3, 32'h0000_00FF);
        wait_ready(low);
        check("busy_rx", 32'(rd_data[7:0]), 32'h66);
        check("busy_slave_rx", 32'(slv_rx), 32'h3C);
        repeat (40) @(negedge clk);
        check("busy_ready_hold", 32'(rd_data[8]), 32'h1);
        check("busy_samples", 32'(slv_samples), 32'd8);
        check("busy_rx_hold", 32'(rd_data[7:0]), 32'h66);
        $display("xfer busy tx=3c rx=%h slave_rx=%h", rd_data[7:0], slv_rx);

        // Mode 3, dvsr=0
        write_reg(5'd2, 32'h0003_0000);
        tb_cpol = 1'b1;
        tb_cpha = 1'b1;
        check("m3_sclk_idle", 32'(spi_sclk), 32'h1);
        arm_slave(8'hC3);
        write_reg(5'd3, 32'h0000_0081);
        wait_ready(low);
        check("m3_ready_low", 32'(low), 32'd17);
        check("m3_rx", 32'(rd_data[7:0]), 32'hC3);
        check("m3_slave_rx", 32'(slv_rx), 32'h81);
        check("m3_falls", 32'(slv_falls), 32'd8);
        check("m3_sclk_end", 32'(spi_sclk), 32'h1);
        $display("xfer mode3 tx=81 rx=%h slave_rx=%h ready_low=%0d", rd_data[7:0], slv_rx, low);

        // Asynchronous reset mid-transfer
        write_reg(5'd2, 32'h0000_0001);
        tb_cpol = 1'b0;
        tb_cpha = 1'b0;
        arm_slave(8'h00);
        write_reg(5'd3, 32'h0000_00FF);
        repeat (9) @(negedge clk);
        check("mid_busy", 32'(rd_data[8]), 32'h0);
        check("mid_mosi", 32'(spi_mosi), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("arst_sclk", 32'(spi_sclk), 32'h0);
        check("arst_mosi", 32'(spi_mosi), 32'h0);
        check("arst_ready", 32'(rd_data[8]), 32'h1);
        check("arst_rx", 32'(rd_data[7:0]), 32'h00);
        check("arst_ss_n", 32'(spi_ss_n), 32'h3);
        @(negedge clk);
        reset = 1'b0;
        $display("xfer reset_mid rd_data=%h", rd_data);

        // Loopback with MISO tied low
        miso_tie = 1'b1;
        write_reg(5'd2, 32'h0004_0002);
`ifdef SPI_LOOPBACK_EN
        lb_exp = 8'h5A;
`else
        lb_exp = 8'h00;
`endif
        write_reg(5'd3, 32'h0000_005A);
        wait_ready(low);
        check("lb_ready_low", 32'(low), 32'd48);
        check("lb_rx", 32'(rd_data[7:0]), 32'(lb_exp));
        $display("xfer loopback tx=5a rx=%h ready_low=%0d", rd_data[7:0], low);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
